// File: rtl/tdc_readout_arbiter.sv
// tdc_readout_arbiter
// Round-robin merger that drains several first-word-fall-through TDC readout
// FIFOs into one registered valid/ready stream. Each grant reads at most
// MAX_BURST words from one source. One arbitration cycle separates grants.
// The source index travels with each word as sideband. A saturating count of
// accepted words is also kept.
module tdc_readout_arbiter #(
  parameter int NSRC      = 4,
  parameter int SRC_BITS  = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic [NSRC-1:0]      SRC_EN,
  input  logic [NSRC-1:0]      SRC_EMPTY,
  input  logic [NSRC*32-1:0]   SRC_DATA,
  output logic [NSRC-1:0]      SRC_READ,
  output logic [31:0]          OUT_DATA,
  output logic [SRC_BITS-1:0]  OUT_SRC,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 BUSY,
  output logic [31:0]          WORD_CNT
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0]          BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [SRC_BITS-1:0] LAST_INIT  = SRC_BITS'(NSRC - 1);

  state_t              state_r, state_s;
  logic [SRC_BITS-1:0] grant_r, grant_s;
  logic [SRC_BITS-1:0] last_r, last_s;
  logic [7:0]          burst_cnt_r, burst_cnt_s;

  logic                space_s;
  logic                rd_s;
  logic                exit_s;
  logic                found_s;
  logic [SRC_BITS-1:0] found_idx_s;
  logic [SRC_BITS-1:0] scan_idx_s;
  logic [31:0]         head_s;

  // Round-robin scan: first enabled, non-empty source after the last one served.
  always_comb begin
    found_s     = 1'b0;
    found_idx_s = '0;
    scan_idx_s  = '0;
    // Walk from farthest to nearest so the nearest candidate wins.
    for (int k = NSRC; k >= 1; k--) begin
      scan_idx_s = SRC_BITS'((int'(last_r) + k) % NSRC);
      if (SRC_EN[scan_idx_s] && !SRC_EMPTY[scan_idx_s]) begin
        found_s     = 1'b1;
        found_idx_s = scan_idx_s;
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Pop qualification, burst-end detection and the granted FIFO head.
  always_comb begin
    space_s = !OUT_VALID || OUT_READY;
    head_s  = SRC_DATA[{grant_r, 5'd0} +: 32];
    rd_s    = (state_r == GRANT) && SRC_EN[grant_r] && !SRC_EMPTY[grant_r] && space_s;
    // The empty flag is the current-cycle one, so a source drained by this
    // cycle's pop is released only on the following cycle.
    exit_s  = (state_r == GRANT) &&
              ((rd_s && (burst_cnt_r == BURST_LAST)) ||
               SRC_EMPTY[grant_r] || !SRC_EN[grant_r]);
  end

  // Pop strobe to the granted source, forced off while reset is asserted.
  always_comb begin
    SRC_READ = '0;
    if (rd_s && !RST) begin
      SRC_READ[grant_r] = 1'b1;
    end else begin
      SRC_READ = '0;
    end
  end

  // FSM next-state: arbitrate in IDLE, count the burst and release in GRANT.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    last_s      = last_r;
    burst_cnt_s = burst_cnt_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s     = GRANT;
          grant_s     = found_idx_s;
          burst_cnt_s = 8'd0;
        end else begin
          state_s     = IDLE;
        end
      end
      GRANT: begin
        if (rd_s) begin
          burst_cnt_s = burst_cnt_r + 8'd1;
        end else begin
          burst_cnt_s = burst_cnt_r;
        end
        if (exit_s) begin
          state_s = IDLE;
          last_s  = grant_r;
        end else begin
          state_s = GRANT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register with synchronous reset.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      grant_r     <= '0;
      last_r      <= LAST_INIT;
      burst_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      grant_r     <= grant_s;
      last_r      <= last_s;
      burst_cnt_r <= burst_cnt_s;
    end
  end

  // Output holding register and saturating accepted-word counter.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      OUT_DATA  <= 32'd0;
      OUT_SRC   <= '0;
      OUT_VALID <= 1'b0;
      WORD_CNT  <= 32'd0;
    end else begin
      if (rd_s) begin
        OUT_DATA  <= head_s;
        OUT_SRC   <= grant_r;
        OUT_VALID <= 1'b1;
      end else if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end else begin
        OUT_VALID <= OUT_VALID;
      end
      if (OUT_VALID && OUT_READY && (WORD_CNT != 32'hFFFF_FFFF)) begin
        WORD_CNT <= WORD_CNT + 32'd1;
      end else begin
        WORD_CNT <= WORD_CNT;
      end
    end
  end

  assign BUSY = (state_r == GRANT);

endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// tb_tdc_readout_arbiter
// Directed bench for the TDC readout arbiter. It models the source FIFOs as
// queues. A per-cycle monitor checks pop legality and scores every accepted
// word against the words pushed into each source.
module tb_tdc_readout_arbiter;

  localparam int NSRC = 4;

  logic               BUS_CLK;
  logic               RST;
  logic [NSRC-1:0]    SRC_EN;
  logic [NSRC-1:0]    SRC_EMPTY;
  logic [NSRC*32-1:0] SRC_DATA;
  logic [NSRC-1:0]    SRC_READ;
  logic [31:0]        OUT_DATA;
  logic [1:0]         OUT_SRC;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic               BUSY;
  logic [31:0]        WORD_CNT;

  tdc_readout_arbiter #(.NSRC(4), .SRC_BITS(2), .MAX_BURST(16)) dut (
    .BUS_CLK  (BUS_CLK),
    .RST      (RST),
    .SRC_EN   (SRC_EN),
    .SRC_EMPTY(SRC_EMPTY),
    .SRC_DATA (SRC_DATA),
    .SRC_READ (SRC_READ),
    .OUT_DATA (OUT_DATA),
    .OUT_SRC  (OUT_SRC),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .BUSY     (BUSY),
    .WORD_CNT (WORD_CNT)
  );

  logic [31:0] srcq [NSRC][$];
  logic [31:0] expq [NSRC][$];
  logic [1:0]  acc_src [$];
  int          pop_cnt [NSRC];
  logic [23:0] seq [NSRC];
  int          checks = 0;
  int          passed = 0;

  initial begin
    BUS_CLK = 1'b0;
    forever #5 BUS_CLK = ~BUS_CLK;
  end

  task automatic refresh();
    for (int i = 0; i < NSRC; i++) begin
      SRC_EMPTY[i] = (srcq[i].size() == 0);
      SRC_DATA[32*i +: 32] = (srcq[i].size() == 0) ? 32'h0 : srcq[i][0];
    end
  endtask

  task automatic push_word(input int s, input logic [31:0] w);
    srcq[s].push_back(w);
    expq[s].push_back(w);
  endtask

  task automatic push_seq(input int s);
    logic [3:0] sb;
    sb = 4'(s);
    push_word(s, {4'h4, sb, seq[s]});
    seq[s] = seq[s] + 24'd1;
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (srcq[i].size() != 0 || expq[i].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  // One clock: monitor before the edge, model FIFO pops at the edge, refresh after.
  task automatic tick();
    logic [NSRC-1:0] rd;
    logic            acc;
    logic [31:0]     d;
    logic [31:0]     exp_w;
    logic [1:0]      s;
    bit              bad;
    #1;
    rd  = SRC_READ;
    acc = OUT_VALID && OUT_READY && !RST;
    d   = OUT_DATA;
    s   = OUT_SRC;
    bad = 1'b0;
    if (RST && rd != '0) bad = 1'b1;
    if ($countones(rd) > 1) bad = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (rd[i] && (srcq[i].size() == 0 || !SRC_EN[i])) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL read_legal t=%0t SRC_READ=%b EMPTY=%b EN=%b RST=%b required one legal pop at most", $time, rd, SRC_EMPTY, SRC_EN, RST);
    else passed++;
    if (acc) begin
      checks++;
      if (expq[s].size() == 0) begin
        $display("FAIL scoreboard src=%0d got %h required no word pending", s, d);
      end else begin
        exp_w = expq[s].pop_front();
        if (d !== exp_w) $display("FAIL scoreboard src=%0d got %h required %h", s, d, exp_w);
        else passed++;
      end
      acc_src.push_back(s);
    end
    @(posedge BUS_CLK);
    for (int i = 0; i < NSRC; i++) begin
      if (rd[i] && srcq[i].size() != 0) begin
        void'(srcq[i].pop_front());
        pop_cnt[i]++;
      end
    end
    #1;
    refresh();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    OUT_READY = 1'b1;
    while (n < 2000 && !(all_empty() && !OUT_VALID)) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2000) $display("FAIL %s_drain timed out, required all words delivered", name);
    else passed++;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      srcq[i].delete();
      expq[i].delete();
      pop_cnt[i] = 0;
    end
    acc_src.delete();
    refresh();
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    SRC_EN    = 4'b1111;
    OUT_READY = 1'b1;
    for (int i = 0; i < NSRC; i++) seq[i] = 24'd1;
    do_reset();
    checks++;
    if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || WORD_CNT !== 32'd0 || OUT_DATA !== 32'd0 || OUT_SRC !== 2'd0)
      $display("FAIL reset got valid=%b busy=%b cnt=%0d data=%h src=%0d required all zero", OUT_VALID, BUSY, WORD_CNT, OUT_DATA, OUT_SRC);
    else passed++;
  endtask

  task automatic test_single();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h4000_0001;
    exp_d[1] = 32'h4000_0002;
    exp_d[2] = 32'h4000_0003;
    for (int i = 0; i < 3; i++) push_seq(0);
    refresh();
    tick();
    checks++;
    if (BUSY !== 1'b1 || OUT_VALID !== 1'b0) $display("FAIL single_arb got busy=%b valid=%b required 1/0", BUSY, OUT_VALID);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_d[k] || OUT_SRC !== 2'd0)
        $display("FAIL single_word%0d got v=%b d=%h s=%0d required 1 %h 0", k, OUT_VALID, OUT_DATA, OUT_SRC, exp_d[k]);
      else passed++;
    end
    tick();
    checks++;
    if (pop_cnt[0] !== 3 || WORD_CNT !== 32'd3 || OUT_VALID !== 1'b0 || BUSY !== 1'b0)
      $display("FAIL single_end got pops=%0d cnt=%0d v=%b busy=%b required 3 3 0 0", pop_cnt[0], WORD_CNT, OUT_VALID, BUSY);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_src [$];
    int         bad;
    int         burst;
    do_reset();
    for (int s = 0; s < NSRC; s++) for (int k = 0; k < 40; k++) push_seq(s);
    refresh();
    for (int r = 0; r < 3; r++) begin
      burst = (r < 2) ? 16 : 8;
      for (int s = 0; s < NSRC; s++) for (int k = 0; k < burst; k++) exp_src.push_back(2'(s));
    end
    drain("rr");
    bad = 0;
    for (int k = 0; k < 160 && k < acc_src.size(); k++) if (acc_src[k] !== exp_src[k]) bad++;
    checks++;
    if (acc_src.size() != 160 || bad != 0)
      $display("FAIL rr_order got %0d words with %0d out-of-order sources required 160 with 0", acc_src.size(), bad);
    else passed++;
    checks++;
    if (WORD_CNT !== 32'd160) $display("FAIL rr_count got %0d required 160", WORD_CNT);
    else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 1; k <= 5; k++) push_word(1, 32'h4100_0100 + 32'(k));
    refresh();
    OUT_READY = 1'b0;
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (pop_cnt[1] !== 1 || OUT_VALID !== 1'b1 || OUT_DATA !== 32'h4100_0101 || OUT_SRC !== 2'd1)
        $display("FAIL bp_stall%0d got pops=%0d v=%b d=%h required 1 1 41000101", c, pop_cnt[1], OUT_VALID, OUT_DATA);
      else passed++;
    end
    OUT_READY = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick();
      checks++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== (32'h4100_0100 + 32'(k)))
        $display("FAIL bp_stream%0d got v=%b d=%h required 1 %h", k, OUT_VALID, OUT_DATA, 32'h4100_0100 + 32'(k));
      else passed++;
    end
    tick();
    checks++;
    if (WORD_CNT !== 32'd5 || OUT_VALID !== 1'b0) $display("FAIL bp_count got %0d v=%b required 5 0", WORD_CNT, OUT_VALID);
    else passed++;
  endtask

  task automatic test_enable();
    int n;
    int hits2;
    do_reset();
    SRC_EN = 4'b1011;
    for (int s = 0; s < NSRC; s++) for (int k = 0; k < 20; k++) push_seq(s);
    refresh();
    n = 0;
    while (n < 1000 && !(srcq[0].size() == 0 && srcq[1].size() == 0 && srcq[3].size() == 0 && !OUT_VALID)) begin
      tick();
      n++;
    end
    hits2 = 0;
    foreach (acc_src[k]) if (acc_src[k] == 2'd2) hits2++;
    checks++;
    if (n >= 1000 || pop_cnt[2] !== 0 || hits2 != 0 || acc_src.size() != 60)
      $display("FAIL en_mask got cycles=%0d pops2=%0d words2=%0d total=%0d required <1000 0 0 60", n, pop_cnt[2], hits2, acc_src.size());
    else passed++;
    do_reset();
    SRC_EN = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      push_seq(0);
      push_seq(1);
    end
    refresh();
    tick();
    tick();
    tick();
    SRC_EN = 4'b1110;
    tick();
    checks++;
    if (BUSY !== 1'b0) $display("FAIL en_release got busy=%b required 0", BUSY);
    else passed++;
    tick();
    checks++;
    if (BUSY !== 1'b1) $display("FAIL en_regrant got busy=%b required 1", BUSY);
    else passed++;
    tick();
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_SRC !== 2'd1) $display("FAIL en_next_src got v=%b src=%0d required 1 1", OUT_VALID, OUT_SRC);
    else passed++;
    SRC_EN = 4'b1111;
    drain("en");
  endtask

  task automatic test_rst_midburst();
    int pops_before;
    for (int k = 0; k < 10; k++) push_seq(2);
    refresh();
    tick();
    tick();
    tick();
    RST = 1'b1;
    pops_before = pop_cnt[2];
    tick();
    checks++;
    if (OUT_VALID !== 1'b0 || WORD_CNT !== 32'd0 || BUSY !== 1'b0 || pop_cnt[2] !== pops_before)
      $display("FAIL rst_mid got v=%b cnt=%0d busy=%b pops=%0d required 0 0 0 %0d", OUT_VALID, WORD_CNT, BUSY, pop_cnt[2], pops_before);
    else passed++;
    RST = 1'b0;
    // The second word was held in the output register and discarded by reset.
    void'(expq[2].pop_front());
    for (int k = 0; k < 4; k++) push_seq(0);
    refresh();
    tick();
    tick();
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_SRC !== 2'd0) $display("FAIL rst_scan got v=%b src=%0d required 1 0", OUT_VALID, OUT_SRC);
    else passed++;
    drain("rst");
  endtask

  task automatic test_random();
    int pushed;
    do_reset();
    pushed = 0;
    for (int c = 0; c < 10000; c++) begin
      OUT_READY = 1'($urandom_range(0, 1));
      for (int s = 0; s < NSRC; s++) begin
        if (srcq[s].size() < 32 && $urandom_range(0, 2) == 0) begin
          push_seq(s);
          pushed++;
        end
      end
      refresh();
      tick();
    end
    drain("rand");
    checks++;
    if (WORD_CNT !== 32'(pushed)) $display("FAIL rand_count got %0d required %0d", WORD_CNT, pushed);
    else passed++;
  endtask

  initial begin
    RST       = 1'b1;
    SRC_EN    = 4'b1111;
    OUT_READY = 1'b1;
    SRC_EMPTY = '1;
    SRC_DATA  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_enable();
    test_rst_midburst();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tdc_readout_arbiter.md
Name: tdc_readout_arbiter

Overview:
- Round-robin merger placed directly downstream of several TDC core instances. It drains each core's 32-bit first-word-fall-through readout FIFO (the FIFO_READ / FIFO_EMPTY / FIFO_DATA interface) into a single valid/ready output stream.
- Data words pass through unmodified; the 4-bit data identifier stays in bits [31:28].
- The output stream feeds the common readout FIFO / SiTCP path. The source index is provided as sideband, and a total word count is kept.

Parameters:
- NSRC, 4, number of TDC sources (2..16)
- SRC_BITS, 2, width of source index; must satisfy 2**SRC_BITS >= NSRC
- MAX_BURST, 16, maximum words read from one source per grant (1..255)

Ports:
- BUS_CLK  in  1  clock; all logic in this domain
- RST  in  1  reset, synchronous, active-high
- SRC_EN  in  NSRC  per-source enable mask; disabled sources are never granted
- SRC_EMPTY  in  NSRC  source FIFO empty flags
- SRC_DATA  in  NSRC*32  source FIFO heads; source i occupies bits [32*i+31:32*i]; valid while SRC_EMPTY[i]=0
- SRC_READ  out  NSRC  one-cycle pop strobe per source (combinational)
- OUT_DATA  out  32  registered output word
- OUT_SRC  out  SRC_BITS  index of the source OUT_DATA came from
- OUT_VALID  out  1  OUT_DATA/OUT_SRC valid
- OUT_READY  in  1  consumer accepts the word when OUT_VALID & OUT_READY
- BUSY  out  1  high while state == GRANT
- WORD_CNT  out  32  words accepted at output since reset; saturates at 0xFFFFFFFF

Behaviour:
- Reset values:
  - state=IDLE, grant=0, last=NSRC-1 (so the first scan starts at source 0)
  - burst_cnt=0, OUT_DATA=0, OUT_SRC=0, OUT_VALID=0, WORD_CNT=0, BUSY=0
  - SRC_READ=0 in any cycle where RST=1 (gated combinationally).
- Output register rules:
  - "space" = !OUT_VALID | OUT_READY.
  - On an accept (OUT_VALID & OUT_READY) with no new load, OUT_VALID goes to 0 next cycle.
  - A load sets OUT_VALID=1 and overwrites OUT_DATA/OUT_SRC. A simultaneous accept and load is legal and sustains 1 word/cycle.
  - WORD_CNT increments on each accept.
- IDLE:
  - Scan sources last+1 .. last+NSRC (mod NSRC) for the first i with SRC_EN[i] & !SRC_EMPTY[i].
  - If one is found: grant<=i, burst_cnt<=0, go to GRANT. No read happens in this cycle.
  - If none is found: stay in IDLE.
- GRANT, with rd = SRC_EN[grant] & !SRC_EMPTY[grant] & space:
  - When rd=1:
    - SRC_READ[grant]=1 in the same cycle.
    - Load OUT_DATA<=SRC_DATA[grant], OUT_SRC<=grant, OUT_VALID<=1; burst_cnt++.
  - Exit to IDLE with last<=grant if any of these holds:
    - (a) rd=1 and burst_cnt == MAX_BURST-1;
    - (b) SRC_EMPTY[grant]=1;
    - (c) SRC_EN[grant]=0.
  - Exit (b) is evaluated on the current-cycle flag, so a source that empties after a pop is released on the following cycle.
  - When !space (backpressure) and the source is not empty, stay in GRANT with no read and no burst_cnt change.
- Latency and throughput:
  - Source word visible -> OUT_VALID: 2 cycles when starting from IDLE (1 arbitration cycle + 1 register), 1 cycle within a burst.
  - There is one idle arbitration cycle between grants.
- At most one SRC_READ bit is high in any cycle. SRC_READ is never asserted to an empty or disabled source.
- Words are never dropped or duplicated; per-source word order is preserved.
- RST mid-burst: all state returns to reset values on the next edge. A word held in the output register and not yet accepted is discarded. No pop occurs during the reset cycle.

Test Plan:
- Single source 0 holding 3 words (0x4000_0001..3), OUT_READY=1 -> IDLE 1 cycle, then 3 consecutive OUT_VALID words in order, OUT_SRC=0, SRC_READ[0] pulsed exactly 3 times, WORD_CNT=3.
- All 4 sources each holding 40 words, MAX_BURST=16 -> grants in the order 0,1,2,3,0,... with bursts of 16,16,8 words per source. All 160 words are delivered with per-source order intact, and no two SRC_READ bits are ever high together.
- Source 1 holding 5 words, OUT_READY held at 0 for 10 cycles, then 1 -> only the first word is popped while stalled, OUT_DATA stays stable and OUT_VALID stays 1. After release the remaining 4 words stream at 1/cycle, WORD_CNT=5.
- SRC_EN=4'b1011 with all sources non-empty -> source 2 is never granted and SRC_READ[2] is never asserted. Clearing SRC_EN[0] mid-burst -> return to IDLE within 1 cycle, and source 1 is granted next.
- RST asserted for 1 cycle mid-burst while OUT_VALID=1 -> the next cycle shows OUT_VALID=0, WORD_CNT=0, no SRC_READ during reset, and the next scan starts at source 0.
- With a data pattern where each word encodes its source and sequence number, run random OUT_READY (50%) and random source fill over 10k cycles -> a scoreboard shows zero loss, zero duplication, and correct OUT_SRC on every word.
